// File: rtl/neuron_pkg.sv
// neuron_pkg: shared Q8.24 defaults, saturation/clamp constants and FSM state type.
package neuron_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_FBITS = 24;
   localparam logic [31:0] Q_ONE     = 32'h0100_0000;
   localparam logic [31:0] Q_NEG_ONE = 32'hFF00_0000;
   localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
   localparam logic [31:0] Q_MIN     = 32'h8000_0000;
   typedef enum logic [2:0] {IDLE, ACC, DRAIN, FIN, OUT} state_t;
endpackage

// File: rtl/mult_Q.sv
// mult_Q: signed fixed-point multiply, full-width product floor-shifted by FBITS.
module mult_Q #(
   parameter int WIDTH = 32,
   parameter int FBITS = 24,
   parameter int OUT_W = 40
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic        [OUT_W-1:0] p
);
   logic signed [2*WIDTH-1:0] full;
   assign full = a * b;
   assign p = OUT_W'(full >>> FBITS);
endmodule

// File: rtl/neuron_h_sat_clamp.sv
// sat_clamp: saturates a wide signed sum to WIDTH bits; with NEURON_H_HARDTANH_EN
// defined it further clamps the result to [-1.0, +1.0].
module sat_clamp
   import neuron_pkg::*;
#(
   parameter int IN_W  = 41,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [IN_W-1:0]  d,
   output logic [WIDTH-1:0] q
);
   localparam logic [WIDTH-1:0] MX = {1'b0, {(WIDTH-1){1'b1}}};
   logic [WIDTH-1:0] s;
   logic fits;
   // the value fits when every bit above the WIDTH sign bit copies it
   assign fits = &d[IN_W-1:WIDTH-1] | ~|d[IN_W-1:WIDTH-1];
   assign s = fits ? d[WIDTH-1:0] : d[IN_W-1] ? ~MX : MX;
`ifdef NEURON_H_HARDTANH_EN
   localparam logic [WIDTH-1:0] ONE = WIDTH'(Q_ONE);
   localparam logic [WIDTH-1:0] NEG = WIDTH'($signed(Q_NEG_ONE));
   assign q = $signed(s) > $signed(ONE) ? ONE : $signed(s) < $signed(NEG) ? NEG : s;
`else
   assign q = s;
`endif
endmodule

// File: rtl/neuron_h_serial.sv
// neuron_h_serial: serial hidden-layer neuron, sum(x*w)+bias saturated to Q8.24.
// Optional hard-tanh output clamp selected by NEURON_H_HARDTANH_EN.
module neuron_h_serial
   import neuron_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FBITS = DEF_FBITS,
   parameter int N_IN  = 2,
   parameter int GUARD = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] bias,
   input  logic             x_valid,
   output logic             x_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] w,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);
   localparam int ACC_W = WIDTH + GUARD;
   localparam int CW = N_IN > 1 ? $clog2(N_IN) : 1;
   state_t state, nxt;
   logic [ACC_W-1:0] acc, p_q, prod;
   logic [ACC_W:0] sum;
   logic [WIDTH-1:0] bias_q, sat;
   logic [CW-1:0] cnt;
   logic p_vld, hs, ld, last;

   mult_Q #(.WIDTH(WIDTH), .FBITS(FBITS), .OUT_W(ACC_W)) u_mul (.a(x), .b(w), .p(prod));

   assign sum = {acc[ACC_W-1], acc} + {{(GUARD+1){bias_q[WIDTH-1]}}, bias_q};

   sat_clamp #(.IN_W(ACC_W+1), .WIDTH(WIDTH)) u_sat (.d(sum), .q(sat));

   assign hs   = x_valid & x_ready;
   assign last = cnt == CW'(N_IN-1);
   // start is honoured only from IDLE or while the current result is being consumed
   assign ld   = start & (state == IDLE | (state == OUT & out_ready));

   always_comb begin
      x_ready   = state == ACC;
      busy      = state != IDLE;
      out_valid = state == OUT;
      nxt = ld ? ACC :
            state == ACC   ? (hs && last ? DRAIN : ACC) :
            state == DRAIN ? FIN :
            state == FIN   ? OUT :
            state == OUT   ? (out_ready ? IDLE : OUT) : IDLE;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         acc    <= '0;
         p_q    <= '0;
         p_vld  <= 1'b0;
         cnt    <= '0;
         bias_q <= '0;
         y      <= '0;
      end else begin
         if (ld) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= bias;
         end else begin
            if (p_vld) acc <= acc + p_q;
            if (hs) cnt <= cnt + 1'b1;
         end
         p_vld <= hs;
         if (hs) p_q <= prod;
         if (state == FIN) y <= sat;
      end
endmodule

// File: tb/tb_neuron_h_serial.sv
// tb_neuron_h_serial: directed checks of neuron_h_serial; expectations follow
// NEURON_H_HARDTANH_EN when the bench is built with it.
module tb_neuron_h_serial;
   import neuron_pkg::*;
   localparam logic [31:0] HALF    = 32'h0080_0000;
   localparam logic [31:0] QUARTER = 32'h0040_0000;
   localparam logic [31:0] NQUART  = 32'hFFC0_0000;
   localparam logic [31:0] TWO     = 32'h0200_0000;
   localparam logic [31:0] EIGHTH  = 32'h0020_0000;
   localparam logic [31:0] BIG     = 32'h6400_0000;
`ifdef NEURON_H_HARDTANH_EN
   localparam logic [31:0] EXP_OVF = Q_ONE;
   localparam logic [31:0] EXP_NEG = Q_NEG_ONE;
`else
   localparam logic [31:0] EXP_OVF = Q_MAX;
   localparam logic [31:0] EXP_NEG = 32'hFEC0_0000;
`endif

   logic clock = 0, reset = 0, start = 0, x_valid = 0, out_ready = 0;
   logic x_ready, out_valid, busy;
   logic [31:0] bias = 0, x = 0, w = 0, y, y_hold;
   int total = 0, bad = 0;

   neuron_h_serial dut (
      .clock(clock), .reset(reset), .start(start), .bias(bias),
      .x_valid(x_valid), .x_ready(x_ready), .x(x), .w(w),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic go(input logic [31:0] b);
      @(negedge clock);
      start = 1; bias = b;
      @(negedge clock);
      start = 0;
   endtask

   task automatic beat(input logic [31:0] xv, input logic [31:0] wv);
      int n = 0;
      x_valid = 1; x = xv; w = wv;
      while (!x_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n == 20) chk("beat_rdy", {31'b0, x_ready}, 32'd1);
      @(posedge clock);
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("out_to", {31'b0, out_valid}, 32'd1);
   endtask

   task automatic feed(input logic [31:0] b, input logic [31:0] x0, input logic [31:0] w0,
                       input logic [31:0] x1, input logic [31:0] w1);
      go(b);
      beat(x0, w0);
      @(negedge clock); x_valid = 0;
      beat(x1, w1);
      @(negedge clock); x_valid = 0;
      wait_out();
   endtask

   task automatic consume();
      y_hold = y;
      out_ready = 1;
      @(negedge clock);
      out_ready = 0;
      chk("cons_ov", {31'b0, out_valid}, 32'd0);
      chk("cons_busy", {31'b0, busy}, 32'd0);
      chk("cons_y", y, y_hold);
   endtask

   initial begin
      #12;
      chk("rst_y", y, 32'd0);
      chk("rst_ov", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_xr", {31'b0, x_ready}, 32'd0);
      @(negedge clock); reset = 1;

      // nominal with exact latency
      go(QUARTER);
      chk("nom_busy", {31'b0, busy}, 32'd1);
      beat(Q_ONE, HALF);
      @(negedge clock); x_valid = 0;
      beat(HALF, HALF);
      @(negedge clock); x_valid = 0;
      chk("lat0_ov", {31'b0, out_valid}, 32'd0);
      chk("drain_xr", {31'b0, x_ready}, 32'd0);
      @(negedge clock);
      chk("lat1_ov", {31'b0, out_valid}, 32'd0);
      chk("lat1_busy", {31'b0, busy}, 32'd1);
      @(negedge clock);
      chk("lat2_ov", {31'b0, out_valid}, 32'd1);
      chk("nom_y", y, Q_ONE);
      consume();

      // bubbles between beats
      go(QUARTER);
      beat(Q_ONE, HALF);
      @(negedge clock); x_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("gap_xr", {31'b0, x_ready}, 32'd1);
         @(negedge clock);
      end
      beat(HALF, HALF);
      @(negedge clock); x_valid = 0;
      wait_out();
      chk("gap_y", y, Q_ONE);
      consume();

      feed(32'd0, BIG, BIG, BIG, BIG);
      chk("ovf_y", y, EXP_OVF);
      consume();

      feed(NQUART, Q_NEG_ONE, HALF, Q_NEG_ONE, HALF);
      chk("neg_y", y, EXP_NEG);

      // stall with an ignored start, then back-to-back start on the handshake
      y_hold = y;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         bias = QUARTER;
         @(negedge clock);
         chk("stall_ov", {31'b0, out_valid}, 32'd1);
         chk("stall_y", y, y_hold);
         chk("stall_xr", {31'b0, x_ready}, 32'd0);
      end
      start = 1; out_ready = 1; bias = EIGHTH;
      @(negedge clock);
      start = 0; out_ready = 0;
      chk("b2b_ov", {31'b0, out_valid}, 32'd0);
      chk("b2b_xr", {31'b0, x_ready}, 32'd1);
      beat(TWO, QUARTER);
      @(negedge clock); x_valid = 0;
      beat(Q_NEG_ONE, HALF);
      @(negedge clock); x_valid = 0;
      wait_out();
      chk("b2b_y", y, EIGHTH);
      consume();

      // asynchronous reset mid-accumulation
      go(QUARTER);
      beat(Q_ONE, HALF);
      @(negedge clock); x_valid = 0;
      reset = 0;
      #1;
      chk("arst_ov", {31'b0, out_valid}, 32'd0);
      chk("arst_y", y, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      @(negedge clock); reset = 1;
      feed(QUARTER, Q_ONE, HALF, HALF, HALF);
      chk("post_rst_y", y, Q_ONE);
      consume();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
